// File: rtl/layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// layer_pkg
// Shared constants, FSM state type and address-width helper for the
// fully-connected layer sequencer.
// Optional feature macro: LAYER_SEQUENCER_BIAS_EN (adds the BIAS state and
// widens the weight address space to cover one bias word per neuron).
// -----------------------------------------------------------------------------
package layer_pkg;

    localparam int unsigned ELEMENTS_PER_VECTOR = 9;
    localparam int unsigned ROW_END_0           = 2;
    localparam int unsigned ROW_END_1           = 5;
    localparam int unsigned IDX_W               = 4;

`ifdef LAYER_SEQUENCER_BIAS_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_BIAS,
        S_EMIT,
        S_DONE
    } layer_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } layer_state_t;
`endif

    // Weight memory holds NUM_NEURONS*9 weights, plus NUM_NEURONS bias words
    // appended after them when the bias feature is built in.
    function automatic int unsigned waddr_width(input int unsigned num_neurons);
`ifdef LAYER_SEQUENCER_BIAS_EN
        return $clog2(num_neurons * 10);
`else
        return $clog2(num_neurons * ELEMENTS_PER_VECTOR);
`endif
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// layer_sequencer_if
// Datapath-side bundle between the layer sequencer (master) and the MAC,
// weight memory, input buffer and result consumer (slave).
//   acc_clear     zero the accumulator
//   mac_en        accumulate this cycle's product
//   input_addr    element index 0..8
//   weight_addr   neuron_index*9 + element (or bias word address)
//   neuron_index  current neuron
//   new_row       kernel row boundary during MAC cycles
//   result_valid  accumulator holds a final dot product
//   result_ready  consumer accepts the current result (slave -> master)
//   bias_en       add bias this cycle (only with LAYER_SEQUENCER_BIAS_EN)
// -----------------------------------------------------------------------------
interface layer_sequencer_if #(
    parameter int unsigned WADDR_W = 6
) ();
    logic               acc_clear;
    logic               mac_en;
    logic [3:0]         input_addr;
    logic [WADDR_W-1:0] weight_addr;
    logic [3:0]         neuron_index;
    logic               new_row;
    logic               result_valid;
    logic               result_ready;
    logic               bias_en;

    modport master (
        output acc_clear,
        output mac_en,
        output input_addr,
        output weight_addr,
        output neuron_index,
        output new_row,
        output result_valid,
        output bias_en,
        input  result_ready
    );

    modport slave (
        input  acc_clear,
        input  mac_en,
        input  input_addr,
        input  weight_addr,
        input  neuron_index,
        input  new_row,
        input  result_valid,
        input  bias_en,
        output result_ready
    );
endinterface

// File: rtl/layer_sequencer_element_index_counter.sv
// -----------------------------------------------------------------------------
// element_index_counter
// Steps the 3x3 kernel element index while the sequencer is accumulating and
// flags the row boundaries after elements 2 and 5.
//   clock    rising-edge clock
//   clr      synchronous clear (layer reset or LOAD)
//   en       advance the index; also gates new_row
//   idx      current element index (registered)
//   new_row  high while en and idx is a row-end element
// -----------------------------------------------------------------------------
module element_index_counter
    import layer_pkg::*;
(
    input  logic             clock,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic             new_row
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (en) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx     = idx_q;
    assign new_row = en && ((idx_q == IDX_W'(ROW_END_0)) || (idx_q == IDX_W'(ROW_END_1)));

endmodule

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Sequences one fully-connected layer over the shared MAC datapath: per neuron
// it clears the accumulator, walks the 9 kernel elements driving weight/input
// addresses, then holds the finished dot product until the consumer accepts it.
// Optional feature macro: LAYER_SEQUENCER_BIAS_EN inserts a one-cycle BIAS
// state between ACCUM and EMIT that addresses the neuron's bias word.
//   clock   rising-edge clock
//   clear   synchronous active-high reset
//   start   begin layer (sampled only in IDLE)
//   busy    high in every state except IDLE
//   done    one-cycle pulse at end of layer
//   bus     layer_sequencer_if.master (MAC / memory / result handshake)
// All outputs decode registered state only; no input-to-output path.
// -----------------------------------------------------------------------------
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned WADDR_W     = waddr_width(NUM_NEURONS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    output logic              busy,
    output logic              done,
    layer_sequencer_if.master bus
);

    localparam logic [3:0]       LAST_NEURON  = 4'(NUM_NEURONS - 1);
    localparam logic [IDX_W-1:0] LAST_ELEMENT = IDX_W'(ELEMENTS_PER_VECTOR - 1);
`ifdef LAYER_SEQUENCER_BIAS_EN
    localparam logic [WADDR_W-1:0] BIAS_BASE  = WADDR_W'(NUM_NEURONS * ELEMENTS_PER_VECTOR);
`endif

    layer_state_t state_q;
    layer_state_t state_d;
    logic [3:0]   neuron_q;
    logic [3:0]   neuron_d;

    logic [IDX_W-1:0]   elem_idx;
    logic               elem_new_row;
    logic               in_load;
    logic               in_accum;
    logic [WADDR_W-1:0] neuron_base;

    logic               busy_o;
    logic               done_o;
    logic               acc_clear_o;
    logic               mac_en_o;
    logic [3:0]         input_addr_o;
    logic [WADDR_W-1:0] weight_addr_o;
    logic               result_valid_o;
    logic               bias_en_o;

    assign in_load  = (state_q == S_LOAD);
    assign in_accum = (state_q == S_ACCUM);

    element_index_counter u_elem_cnt (
        .clock   (clock),
        .clr     (clear | in_load),
        .en      (in_accum),
        .idx     (elem_idx),
        .new_row (elem_new_row)
    );

    // neuron_index * 9 as (n << 3) + n
    assign neuron_base = (WADDR_W'(neuron_q) << 3) + WADDR_W'(neuron_q);

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= S_IDLE;
            neuron_q <= '0;
        end else begin
            state_q  <= state_d;
            neuron_q <= neuron_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        neuron_d = neuron_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    neuron_d = '0;
                end
            end
            S_LOAD: begin
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (elem_idx == LAST_ELEMENT) begin
`ifdef LAYER_SEQUENCER_BIAS_EN
                    state_d = S_BIAS;
`else
                    state_d = S_EMIT;
`endif
                end
            end
`ifdef LAYER_SEQUENCER_BIAS_EN
            S_BIAS: begin
                state_d = S_EMIT;
            end
`endif
            S_EMIT: begin
                if (bus.result_ready) begin
                    if (neuron_q == LAST_NEURON) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_LOAD;
                        neuron_d = neuron_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                neuron_d = '0;
            end
            default: begin
                state_d  = S_IDLE;
                neuron_d = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy_o         = (state_q != S_IDLE);
        done_o         = (state_q == S_DONE);
        acc_clear_o    = in_load;
        mac_en_o       = in_accum;
        result_valid_o = (state_q == S_EMIT);
        bias_en_o      = 1'b0;
        input_addr_o   = '0;
        weight_addr_o  = '0;
        if (in_accum) begin
            input_addr_o  = elem_idx;
            weight_addr_o = neuron_base + WADDR_W'(elem_idx);
        end
`ifdef LAYER_SEQUENCER_BIAS_EN
        if (state_q == S_BIAS) begin
            bias_en_o     = 1'b1;
            weight_addr_o = BIAS_BASE + WADDR_W'(neuron_q);
        end
`endif
    end

    assign busy             = busy_o;
    assign done             = done_o;
    assign bus.acc_clear    = acc_clear_o;
    assign bus.mac_en       = mac_en_o;
    assign bus.input_addr   = input_addr_o;
    assign bus.weight_addr  = weight_addr_o;
    assign bus.neuron_index = neuron_q;
    assign bus.new_row      = elem_new_row;
    assign bus.result_valid = result_valid_o;
    assign bus.bias_en      = bias_en_o;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
// Directed bench for layer_sequencer with one NUM_NEURONS=1 and one
// NUM_NEURONS=4 instance. Expected per-cycle outputs are built from the
// layer timing (LOAD, 9x ACCUM, optional BIAS, EMIT + stalls, DONE, IDLE).
// Honours LAYER_SEQUENCER_BIAS_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_layer_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       acc_clear;
        logic       mac_en;
        logic [3:0] in_addr;
        logic [7:0] w_addr;
        logic [3:0] neuron;
        logic       new_row;
        logic       valid;
        logic       bias;
    } obs_t;

    logic clock;
    logic clear;
    logic start1;
    logic start4;
    logic ready;
    logic busy1, done1, busy4, done4;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    // weight address widths: $clog2(9)=4 / $clog2(36)=6, bias: $clog2(10)=4 / $clog2(40)=6
    layer_sequencer_if #(.WADDR_W(4)) bus1 ();
    layer_sequencer_if #(.WADDR_W(6)) bus4 ();

    assign bus1.result_ready = ready;
    assign bus4.result_ready = ready;

    layer_sequencer #(.NUM_NEURONS(1), .WADDR_W(4)) u_dut1 (
        .clock (clock),
        .clear (clear),
        .start (start1),
        .busy  (busy1),
        .done  (done1),
        .bus   (bus1.master)
    );

    layer_sequencer #(.NUM_NEURONS(4), .WADDR_W(6)) u_dut4 (
        .clock (clock),
        .clear (clear),
        .start (start4),
        .busy  (busy4),
        .done  (done4),
        .bus   (bus4.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t r;
        r = '0;
        if (sel == 1) begin
            r.busy      = busy1;
            r.done      = done1;
            r.acc_clear = bus1.acc_clear;
            r.mac_en    = bus1.mac_en;
            r.in_addr   = bus1.input_addr;
            r.w_addr    = 8'(bus1.weight_addr);
            r.neuron    = bus1.neuron_index;
            r.new_row   = bus1.new_row;
            r.valid     = bus1.result_valid;
            r.bias      = bus1.bias_en;
        end else begin
            r.busy      = busy4;
            r.done      = done4;
            r.acc_clear = bus4.acc_clear;
            r.mac_en    = bus4.mac_en;
            r.in_addr   = bus4.input_addr;
            r.w_addr    = 8'(bus4.weight_addr);
            r.neuron    = bus4.neuron_index;
            r.new_row   = bus4.new_row;
            r.valid     = bus4.result_valid;
            r.bias      = bus4.bias_en;
        end
        return r;
    endfunction

    // Called at a negedge with the DUT idle: start is sampled at the next edge.
    task automatic run_layer(input int sel, input int unsigned n,
                             input int unsigned stall, input bit noisy);
        obs_t        q[$];
        bit          hold[$];
        obs_t        r;
        obs_t        got;
        int unsigned rows  = 0;
        int unsigned dones = 0;
        for (int unsigned nn = 0; nn < n; nn++) begin
            r = '0; r.busy = 1'b1; r.neuron = 4'(nn); r.acc_clear = 1'b1;
            q.push_back(r); hold.push_back(1'b0);
            for (int unsigned e = 0; e < 9; e++) begin
                r = '0; r.busy = 1'b1; r.neuron = 4'(nn); r.mac_en = 1'b1;
                r.in_addr = 4'(e);
                r.w_addr  = 8'(nn * 9 + e);
                r.new_row = (e == 2) || (e == 5);
                q.push_back(r); hold.push_back(1'b0);
            end
`ifdef LAYER_SEQUENCER_BIAS_EN
            r = '0; r.busy = 1'b1; r.neuron = 4'(nn); r.bias = 1'b1;
            r.w_addr = 8'(n * 9 + nn);
            q.push_back(r); hold.push_back(1'b0);
`endif
            for (int unsigned s = 0; s <= ((nn == 0) ? stall : 0); s++) begin
                r = '0; r.busy = 1'b1; r.neuron = 4'(nn); r.valid = 1'b1;
                q.push_back(r); hold.push_back((nn == 0) && (s < stall));
            end
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1; r.neuron = 4'(n - 1);
        q.push_back(r); hold.push_back(1'b0);
        r = '0;
        q.push_back(r); hold.push_back(1'b0);

        ready = 1'b1;
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        foreach (q[i]) begin
            @(negedge clock);
            start1 = 1'b0;
            start4 = 1'b0;
            if (noisy && q[i].busy) begin
                if (sel == 1) start1 = i[0]; else start4 = i[0];
            end
            ready = !hold[i];
            got = sample(sel);
            if (got.new_row) rows++;
            if (got.done) dones++;
            check($sformatf("n%0d_s%0d_cyc%0d", n, stall, i + 1), 32'(got), 32'(q[i]));
        end
        ready = 1'b1;
        check($sformatf("n%0d_new_row_count", n), rows, 2 * n);
        check($sformatf("n%0d_done_count", n), dones, 1);
    endtask

    initial begin
        obs_t        got;
        int unsigned busy_cnt;
        int unsigned done_cnt;

        clear  = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        ready  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_dut1", 32'(sample(1)), 32'd0);
        check("reset_dut4", 32'(sample(4)), 32'd0);
        clear = 1'b0;

        // single neuron, then full layer, then a 3-cycle EMIT stall
        run_layer(1, 1, 0, 1'b0);
        run_layer(4, 4, 0, 1'b0);
        run_layer(4, 4, 3, 1'b0);

        // clear during ACCUM element 4
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        got = sample(4);
        check("clr_test_load", 32'(got.acc_clear), 32'd1);
        repeat (5) @(negedge clock);
        got = sample(4);
        check("clr_test_elem4", 32'(got.in_addr), 32'd4);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_all_zero", 32'(sample(4)), 32'd0);
        busy_cnt = 0;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clock);
            if (busy4) busy_cnt++;
            if (done4) done_cnt++;
        end
        check("clr_stays_idle", busy_cnt, 0);
        check("clr_no_done", done_cnt, 0);
        run_layer(4, 4, 0, 1'b0);

        // start pulses while busy are ignored
        run_layer(4, 4, 0, 1'b1);

        // start and clear on the same edge: clear wins
        start4 = 1'b1;
        clear  = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        clear  = 1'b0;
        check("start_clear_same_edge", 32'(sample(4)), 32'd0);
        busy_cnt = 0;
        repeat (3) begin
            @(negedge clock);
            if (busy4) busy_cnt++;
        end
        check("start_clear_stays_idle", busy_cnt, 0);
        run_layer(4, 4, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
